// File: rtl/frame_sync_pkg.sv
// Frame_Sync shared definitions: mode/FSM encodings and default frame geometry,
// so the frame former and deformer agree on the sync word and payload size.
package frame_sync_pkg;

    localparam int unsigned FsPreambleLen = 30;
    localparam logic [FsPreambleLen-1:0] FsPreambleVal = 30'h0123425;
    localparam int unsigned FsPayloadLen = 48;

    typedef enum logic [1:0] {
        ModeHunt,
        ModePayload,
        ModeVerify
    } mode_e;

    typedef enum logic [2:0] {
        StInit,
        StWaitIn,
        StReadIn,
        StGetIn,
        StCheckOut,
        StSendData
    } state_e;

endpackage

// File: rtl/frame_deformer_preamble_detector.sv
// Hunt-mode sync word search: right-shifting window with saturating fill count and
// exact match against the pattern, evaluated on the value about to be shifted in.
module frame_deformer_preamble_detector
    import frame_sync_pkg::*;
#(
    parameter int unsigned       Len     = FsPreambleLen,
    parameter logic [Len-1:0]    Pattern = FsPreambleVal
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic shift_i,
    input  logic bit_i,
    output logic match_o
);

    localparam int unsigned FillW = $clog2(Len + 1);

    logic [Len-1:0]   shift_q, shift_d;
    logic [FillW-1:0] fill_q, fill_d;

    // Oldest bit ends up in bit 0, matching the transmit order of the pattern.
    always_comb begin
        shift_d = {bit_i, shift_q[Len-1:1]};
        fill_d  = (fill_q == FillW'(Len)) ? fill_q : fill_q + FillW'(1);
    end

    assign match_o = shift_i && (fill_d == FillW'(Len)) && (shift_d == Pattern);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shift_q <= '0;
            fill_q  <= '0;
        end else if (clear_i) begin
            fill_q <= '0;
        end else if (shift_i) begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/frame_deformer.sv
// Receive-side frame sync: hunts for the preamble, strips it from every frame and
// forwards payload bits, verifying each expected preamble with an error tolerance.
module frame_deformer
    import frame_sync_pkg::*;
#(
    parameter int unsigned                 PreambleLen = frame_sync_pkg::FsPreambleLen,
    parameter logic [PreambleLen-1:0]      PreambleVal = frame_sync_pkg::FsPreambleVal,
    parameter int unsigned                 PayloadLen  = frame_sync_pkg::FsPayloadLen,
    parameter int unsigned                 MaxErrors   = 2,
    parameter int unsigned                 MissLimit   = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic fifo_in_data_i,
    output logic fifo_in_re_o,
    input  logic fifo_in_empty_i,
    output logic fifo_out_data_o,
    output logic fifo_out_we_o,
    input  logic fifo_out_full_i,
    output logic locked_o,
    output logic sync_err_o
);

    localparam int unsigned CntW  = $clog2(PreambleLen + 1);
    localparam int unsigned PayW  = $clog2(PayloadLen);
    localparam int unsigned MissW = $clog2(MissLimit + 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CntW-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CntW-1:0]  err_cnt_q, err_cnt_d;
    logic [PayW-1:0]  pay_cnt_q, pay_cnt_d;
    logic [MissW-1:0] miss_cnt_q, miss_cnt_d;
    logic             data_q, data_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    logic             hunt_shift, hunt_clear, hunt_match, bit_err;
    logic [CntW-1:0]  err_total;

    frame_deformer_preamble_detector #(
        .Len     (PreambleLen),
        .Pattern (PreambleVal)
    ) u_detector (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (hunt_clear),
        .shift_i (hunt_shift),
        .bit_i   (fifo_in_data_i),
        .match_o (hunt_match)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pre_cnt_d  = pre_cnt_q;
        err_cnt_d  = err_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        miss_cnt_d = miss_cnt_q;
        data_d     = data_q;
        locked_d   = locked_q;
        sync_err_d = 1'b0;
        hunt_shift = 1'b0;
        hunt_clear = 1'b0;
        bit_err    = fifo_in_data_i != PreambleVal[pre_cnt_q];
        err_total  = err_cnt_q + CntW'(bit_err);

        unique case (state_q)
            StInit:   state_d = StWaitIn;
            StWaitIn: if (!fifo_in_empty_i) state_d = StReadIn;
            StReadIn: state_d = StGetIn;
            StGetIn: begin
                state_d = StWaitIn;
                unique case (mode_q)
                    ModeHunt: begin
                        hunt_shift = 1'b1;
                        if (hunt_match) begin
                            mode_d    = ModePayload;
                            locked_d  = 1'b1;
                            pay_cnt_d = '0;
                        end
                    end
                    ModePayload: begin
                        data_d  = fifo_in_data_i;
                        state_d = StCheckOut;
                    end
                    ModeVerify: begin
                        err_cnt_d = err_total;
                        pre_cnt_d = pre_cnt_q + CntW'(1);
                        if (pre_cnt_q == CntW'(PreambleLen - 1)) begin
                            pre_cnt_d = '0;
                            err_cnt_d = '0;
                            if (err_total <= CntW'(MaxErrors)) begin
                                miss_cnt_d = '0;
                                mode_d     = ModePayload;
                            end else begin
                                sync_err_d = 1'b1;
                                // Flywheel through isolated bad preambles; drop lock on a run.
                                if (miss_cnt_q == MissW'(MissLimit - 1)) begin
                                    mode_d     = ModeHunt;
                                    locked_d   = 1'b0;
                                    hunt_clear = 1'b1;
                                    miss_cnt_d = '0;
                                end else begin
                                    miss_cnt_d = miss_cnt_q + MissW'(1);
                                    mode_d     = ModePayload;
                                end
                            end
                        end
                    end
                    default: begin
                        mode_d     = ModeHunt;
                        locked_d   = 1'b0;
                        hunt_clear = 1'b1;
                    end
                endcase
            end
            StCheckOut: if (!fifo_out_full_i) state_d = StSendData;
            StSendData: begin
                state_d = StWaitIn;
                if (pay_cnt_q == PayW'(PayloadLen - 1)) begin
                    pay_cnt_d = '0;
                    mode_d    = ModeVerify;
                end else begin
                    pay_cnt_d = pay_cnt_q + PayW'(1);
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign fifo_in_re_o    = (state_q == StReadIn);
    assign fifo_out_we_o   = (state_q == StSendData);
    assign fifo_out_data_o = fifo_out_we_o & data_q;
    assign locked_o        = locked_q;
    assign sync_err_o      = sync_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            mode_q     <= ModeHunt;
            pre_cnt_q  <= '0;
            err_cnt_q  <= '0;
            pay_cnt_q  <= '0;
            miss_cnt_q <= '0;
            data_q     <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pre_cnt_q  <= pre_cnt_d;
            err_cnt_q  <= err_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            data_q     <= data_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

endmodule

// File: tb/tb_frame_deformer.sv
// Randomized bench for frame_deformer: a bit-stream level model predicts payload
// output, lock and sync-error behaviour, checked every cycle by one compare process.
module tb_frame_deformer;

    localparam int PLEN   = 30;
    localparam int PAYLEN = 48;
    localparam int MAXE   = 2;
    localparam int MISSL  = 3;
    localparam logic [29:0] PVAL = 30'h0123425;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_data = 1'b0;
    logic in_empty = 1'b1;
    logic out_full = 1'b0;
    logic in_re, out_data, out_we, locked, sync_err;

    always #5 clk = ~clk;

    frame_deformer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .fifo_in_data_i  (in_data),
        .fifo_in_re_o    (in_re),
        .fifo_in_empty_i (in_empty),
        .fifo_out_data_o (out_data),
        .fifo_out_we_o   (out_we),
        .fifo_out_full_i (out_full),
        .locked_o        (locked),
        .sync_err_o      (sync_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit stim[$], stim_clean[$], in_q[$];
    bit exp_q[$], exp_all[$], cap[$], cap_clean[$];
    bit lock_exp[$], serr_exp[$];
    int bit_idx = 0, wr_cnt = 0, serr_cnt = 0, lock_falls = 0;
    bit cur_lock = 0, se_exp = 0, check_en = 0;
    bit re_prev = 0, empty_prev = 1, full_prev = 0, lock_prev = 0;
    bit r1 = 0, r2 = 0;
    bit stall_en = 0, fullrand_en = 0, full_force = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Stream-level reference: walk the received bits through hunt/payload/verify rules.
    task automatic build_model(input bit s[$]);
        int  mode, pc, vc, err, miss;
        bit  lk, se, b, ok;
        bit  hist[$];
        mode = 0; pc = 0; vc = 0; err = 0; miss = 0; lk = 0;
        exp_q.delete(); lock_exp.delete(); serr_exp.delete();
        foreach (s[k]) begin
            b  = s[k];
            se = 0;
            if (mode == 0) begin
                hist.push_back(b);
                if (hist.size() > PLEN) void'(hist.pop_front());
                if (hist.size() == PLEN) begin
                    ok = 1;
                    for (int i = 0; i < PLEN; i++) if (hist[i] != PVAL[i]) ok = 0;
                    if (ok) begin mode = 1; lk = 1; pc = 0; end
                end
            end else if (mode == 1) begin
                exp_q.push_back(b);
                pc++;
                if (pc == PAYLEN) begin pc = 0; mode = 2; end
            end else begin
                if (b != PVAL[vc]) err++;
                vc++;
                if (vc == PLEN) begin
                    if (err <= MAXE) begin
                        miss = 0; mode = 1;
                    end else begin
                        se = 1;
                        if (miss + 1 == MISSL) begin
                            mode = 0; lk = 0; miss = 0; hist.delete();
                        end else begin
                            miss++; mode = 1;
                        end
                    end
                    vc = 0; err = 0;
                end
            end
            lock_exp.push_back(lk);
            serr_exp.push_back(se);
        end
        exp_all = exp_q;
    endtask

    // Compare process: every cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                if (in_re) chk("re_while_empty", empty_prev, 0);
                if (out_we) begin
                    chk("we_while_full", full_prev, 0);
                    if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                    else chk("out_data", out_data, exp_q.pop_front());
                    cap.push_back(out_data);
                    wr_cnt++;
                end else begin
                    chk("out_data_idle", out_data, 0);
                end
                se_exp = 0;
                if (r2) begin
                    if (bit_idx < lock_exp.size()) begin
                        cur_lock = lock_exp[bit_idx];
                        se_exp   = serr_exp[bit_idx];
                    end else begin
                        chk("extra_bit_consumed", 1, 0);
                    end
                    bit_idx++;
                end
                chk("locked", locked, cur_lock);
                chk("sync_err", sync_err, se_exp);
                if (sync_err) serr_cnt++;
                if (lock_prev && !locked) lock_falls++;
            end
            r2 = check_en && r1;
            r1 = check_en && in_re;
            re_prev    = in_re;
            empty_prev = in_empty;
            full_prev  = out_full;
            lock_prev  = locked;
        end
    end

    // Input FIFO and output-full emulation, driven just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (re_prev && in_q.size() > 0) in_data = in_q.pop_front();
        in_empty = (in_q.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
        out_full = full_force || (fullrand_en && $urandom_range(0, 3) == 0);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic push_frame(input int nflip);
        logic [29:0] p;
        p = PVAL;
        for (int k = 0; k < nflip; k++) p[(k * 7 + 2) % 30] = ~p[(k * 7 + 2) % 30];
        for (int i = 0; i < PLEN; i++) stim.push_back(p[i]);
        push_rand(PAYLEN);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_re"}, in_re, 0);
        chk({name, "_we"}, out_we, 0);
        chk({name, "_data"}, out_data, 0);
        chk({name, "_locked"}, locked, 0);
        chk({name, "_sync_err"}, sync_err, 0);
    endtask

    task automatic full_stall();
        full_force = 1;
        out_full   = 1;
        for (int i = 0; i < 19; i++) begin
            tick();
            @(negedge clk);
            if (i >= 3) begin
                chk("full_hold_no_re", in_re, 0);
                chk("full_hold_no_we", out_we, 0);
            end
        end
        full_force = 0;
        tick();
        @(negedge clk);
        chk("full_release_no_we_yet", out_we, 0);
        tick();
        @(negedge clk);
        chk("full_bit10_we", out_we, 1);
        chk("full_bit10_data", out_data, exp_all[10]);
    endtask

    task automatic mid_reset();
        check_en = 0;
        rst_n    = 0;
        tick();
        chk_idle_outputs("midreset");
        rst_n = 1;
        build_model(in_q);
        wr_cnt = 0; serr_cnt = 0; bit_idx = 0; cur_lock = 0;
        cap.delete();
        check_en = 1;
    endtask

    task automatic run_phase(input string name, input int special, input int model_wr,
                             input int exp_wr, input int exp_serr, input bit exp_lock);
        int budget, idle;
        bit done;
        check_en   = 0;
        full_force = 0;
        rst_n      = 0;
        tick();
        tick();
        chk_idle_outputs({name, "_reset"});
        in_q = stim;
        build_model(stim);
        chk({name, "_model_writes"}, exp_q.size(), model_wr);
        wr_cnt = 0; serr_cnt = 0; lock_falls = 0; bit_idx = 0; cur_lock = 0;
        cap.delete();
        rst_n    = 1;
        check_en = 1;
        budget = stim.size() * 15 + 400;
        idle   = 0;
        done   = 0;
        while (!done && budget > 0) begin
            tick();
            budget--;
            if (special == 1 && wr_cnt == 10) begin special = 0; full_stall(); end
            if (special == 2 && wr_cnt == 20) begin special = 0; mid_reset(); end
            if (in_q.size() == 0 && bit_idx >= lock_exp.size()) idle++;
            if (idle > 8) done = 1;
        end
        if (!done) chk({name, "_timeout"}, 1, 0);
        chk({name, "_writes"}, wr_cnt, exp_wr);
        chk({name, "_pending_expected"}, exp_q.size(), 0);
        chk({name, "_sync_err_count"}, serr_cnt, exp_serr);
        chk({name, "_final_locked"}, locked, exp_lock);
        check_en = 0;
    endtask

    initial begin
        // Clean stream: lock on first preamble, all 144 payload bits, no sync errors.
        stim.delete(); push_rand(5); repeat (3) push_frame(0);
        run_phase("clean", 0, 144, 144, 0, 1);
        chk("clean_lock_drops", lock_falls, 0);
        stim_clean = stim;
        cap_clean  = cap;

        // Two flipped bits in frame 2 stay within tolerance.
        stim.delete(); push_rand(5); push_frame(0); push_frame(2); push_frame(0);
        run_phase("flip2", 0, 144, 144, 0, 1);

        // Three flipped bits: one sync error, lock held by the flywheel.
        stim.delete(); push_rand(5); push_frame(0); push_frame(3); push_frame(0);
        run_phase("flip3", 0, 144, 144, 1, 1);
        chk("flip3_lock_drops", lock_falls, 0);

        // Three bad preambles in a row drop lock; the next clean one relocks.
        stim.delete(); push_rand(5); push_frame(0);
        repeat (3) push_frame(3);
        push_frame(0);
        run_phase("lockloss", 0, 192, 192, 3, 1);
        chk("lockloss_lock_drops", lock_falls, 1);

        // Output FIFO full for 20 cycles on payload bit 10.
        stim.delete(); push_rand(5); repeat (2) push_frame(0);
        run_phase("fullstall", 1, 96, 96, 0, 1);

        // Random input starvation and output back-pressure on the clean stream.
        stim = stim_clean;
        stall_en = 1; fullrand_en = 1;
        run_phase("stall", 0, 144, 144, 0, 1);
        stall_en = 0; fullrand_en = 0;
        chk("stall_seq_len", cap.size(), cap_clean.size());
        for (int i = 0; i < cap.size() && i < cap_clean.size(); i++)
            chk("stall_seq_bit", cap[i], cap_clean[i]);

        // Reset after 20 payload bits; only the following frame's payload reappears.
        stim.delete(); push_rand(5); repeat (2) push_frame(0);
        run_phase("midreset", 2, 96, 48, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
